// File: rtl/hu_pkg.sv
// Shared types and constants for the hazard/forwarding unit: tag-pipe entry
// layout, availability stage codes and the stage-index width helper.
package hu_pkg;

    // Entry fields are sized for the largest supported configuration; narrower
    // register/availability fields are zero-extended on insert.
    localparam int MAX_REG_W = 8;
    localparam int MAX_AVW   = 4;

    localparam int AV_EX    = 0;
    localparam int AV_MEM   = 1;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic                 v;
        logic [MAX_REG_W-1:0] rd;
        logic                 we;
        logic [MAX_AVW-1:0]   avail;
    } tag_entry_t;

    function automatic int stg_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hu_tag_pipe.sv
// Destination-tag shift register tracking in-flight writers through the
// back-end stages (index 0 = EX); supports freeze, insert and youngest flush.
module hu_tag_pipe
    import hu_pkg::*;
#(
    parameter int NSTG    = 3,
    parameter int FLUSH_N = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  tag_entry_t            ins,
    output tag_entry_t [NSTG-1:0] entries
);

    tag_entry_t [NSTG-1:0] ent_q;
    tag_entry_t [NSTG-1:0] ent_d;

    // Flush clears the youngest slots even while frozen; the shift itself obeys freeze.
    always_comb begin
        ent_d = ent_q;
        if (!freeze) begin
            ent_d[0] = ins;
            for (int i = 1; i < NSTG; i++) begin
                ent_d[i] = ent_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < NSTG; i++) begin
                if (i < FLUSH_N) begin
                    ent_d[i].v = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign entries = ent_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard and forwarding controller driven by a destination-tag pipe.
// Define HU_FWD_EN to enable EX forwarding; otherwise every RAW match stalls.
module hazard_unit
    import hu_pkg::*;
#(
    parameter int NSTG    = 3,
    parameter int NREG    = 32,
    parameter int AVW     = 2,
    parameter int FLUSH_N = 1,
    localparam int RW     = $clog2(NREG),
    localparam int SW     = stg_w(NSTG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_en,
    input  logic          id_rs2_en,
    input  logic [RW-1:0] id_rd,
    input  logic          id_rd_we,
    input  logic [AVW-1:0] id_avail,
    input  logic          id_no_fw,
    input  logic          stall_ext,
    input  logic          flush,
    output logic          stall_fe,
    output logic          bubble,
    output logic          fw_a_en,
    output logic          fw_b_en,
    output logic [SW-1:0] fw_a_sel,
    output logic [SW-1:0] fw_b_sel
);

`ifdef HU_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    tag_entry_t [NSTG-1:0] ent;
    tag_entry_t            ins;

    logic               a_hit, b_hit;
    logic [SW-1:0]      a_k, b_k;
    logic [MAX_AVW-1:0] a_av, b_av;
    logic               a_blk, b_blk;
    logic               blocked, issue;

    function automatic logic hits(input tag_entry_t e, input logic [RW-1:0] rs, input logic en);
        return e.v && e.we && en && (rs != RW'(ZERO_REG)) && (e.rd == MAX_REG_W'(rs));
    endfunction

    // Scan oldest to youngest so the youngest match (lowest k) is the one kept.
    always_comb begin
        a_hit = 1'b0;
        a_k   = '0;
        a_av  = '0;
        b_hit = 1'b0;
        b_k   = '0;
        b_av  = '0;
        for (int i = NSTG-1; i >= 0; i--) begin
            if (hits(ent[i], id_rs1, id_rs1_en)) begin
                a_hit = 1'b1;
                a_k   = SW'(i);
                a_av  = ent[i].avail;
            end
            if (hits(ent[i], id_rs2, id_rs2_en)) begin
                b_hit = 1'b1;
                b_k   = SW'(i);
                b_av  = ent[i].avail;
            end
        end
    end

    assign a_blk   = a_hit && (id_no_fw || !FWD_EN || (int'(a_k) < int'(a_av)));
    assign b_blk   = b_hit && (id_no_fw || !FWD_EN || (int'(b_k) < int'(b_av)));
    assign blocked = id_valid && (a_blk || b_blk);

    assign stall_fe = blocked || stall_ext;
    assign bubble   = blocked && !stall_ext;
    assign issue    = id_valid && !stall_fe && !flush;

    always_comb begin
        ins       = '0;
        ins.v     = issue;
        ins.rd    = MAX_REG_W'(id_rd);
        ins.we    = id_rd_we;
        ins.avail = MAX_AVW'(id_avail);
    end

    hu_tag_pipe #(
        .NSTG    (NSTG),
        .FLUSH_N (FLUSH_N)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .freeze  (stall_ext),
        .flush   (flush),
        .ins     (ins),
        .entries (ent)
    );

    // Select only moves with a live forward; otherwise EX keeps the old mux setting.
    always_ff @(posedge clk) begin
        if (rst) begin
            fw_a_en  <= 1'b0;
            fw_b_en  <= 1'b0;
            fw_a_sel <= '0;
            fw_b_sel <= '0;
        end else if (!stall_ext) begin
            fw_a_en <= issue && a_hit && !a_blk;
            fw_b_en <= issue && b_hit && !b_blk;
            if (issue && a_hit && !a_blk) begin
                fw_a_sel <= a_k;
            end
            if (issue && b_hit && !b_blk) begin
                fw_b_sel <= b_k;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (NSTG=3); expectations follow HU_FWD_EN
// so the same bench covers both builds.
module tb_hazard_unit;

    localparam int NSTG = 3;

`ifdef HU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_en, id_rs2_en, id_rd_we, id_no_fw, stall_ext, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_avail;
    logic       stall_fe, bubble, fw_a_en, fw_b_en;
    logic [1:0] fw_a_sel, fw_b_sel;

    hazard_unit #(
        .NSTG    (3),
        .NREG    (32),
        .AVW     (2),
        .FLUSH_N (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rs1_en (id_rs1_en),
        .id_rs2_en (id_rs2_en),
        .id_rd     (id_rd),
        .id_rd_we  (id_rd_we),
        .id_avail  (id_avail),
        .id_no_fw  (id_no_fw),
        .stall_ext (stall_ext),
        .flush     (flush),
        .stall_fe  (stall_fe),
        .bubble    (bubble),
        .fw_a_en   (fw_a_en),
        .fw_b_en   (fw_b_en),
        .fw_a_sel  (fw_a_sel),
        .fw_b_sel  (fw_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a_en;
        logic [1:0] a_sel;
        logic       b_en;
        logic [1:0] b_sel;
    } fw_exp_t;

    fw_exp_t fw_q[$];
    fw_exp_t m_fw;

    logic       m_v  [NSTG];
    logic [4:0] m_rd [NSTG];
    logic       m_we [NSTG];
    int         m_av [NSTG];

    int vec_count   = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void findProducer(input logic [4:0] rs, input logic en, output logic hit, output int k);
        hit = 1'b0;
        k   = 0;
        for (int i = 0; i < NSTG; i++) begin
            if (!hit && en && rs != 5'd0 && m_v[i] && m_we[i] && m_rd[i] == rs) begin
                hit = 1'b1;
                k   = i;
            end
        end
    endfunction

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic e1,
                                 input logic [4:0] rs2, input logic e2, input logic [4:0] rd,
                                 input logic we, input logic [1:0] av, input logic nofw,
                                 input logic sext, input logic fl, output logic issued);
        logic    ha, hb, ba, bb, blk, stall_e, bub_e;
        int      ka, kb;
        fw_exp_t nx, prev;
        @(posedge clk);
        #1;
        id_valid  = v;    id_rs1 = rs1; id_rs1_en = e1; id_rs2 = rs2; id_rs2_en = e2;
        id_rd     = rd;   id_rd_we = we; id_avail = av; id_no_fw = nofw;
        stall_ext = sext; flush = fl;

        findProducer(rs1, e1, ha, ka);
        findProducer(rs2, e2, hb, kb);
        ba      = ha && (nofw || !FWD || ka < m_av[ka]);
        bb      = hb && (nofw || !FWD || kb < m_av[kb]);
        blk     = v && (ba || bb);
        stall_e = blk || sext;
        bub_e   = blk && !sext;
        issued  = v && !stall_e && !fl;

        nx = m_fw;
        if (!sext) begin
            nx.a_en = issued && ha;
            nx.b_en = issued && hb;
            if (nx.a_en) nx.a_sel = 2'(ka);
            if (nx.b_en) nx.b_sel = 2'(kb);
        end
        m_fw = nx;
        fw_q.push_back(nx);

        if (!sext) begin
            for (int i = NSTG-1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_av[i] = m_av[i-1];
            end
            m_v[0] = issued; m_rd[0] = rd; m_we[0] = we; m_av[0] = int'(av);
        end
        if (fl) m_v[0] = 1'b0;

        @(negedge clk);
        checkOutput("stall_fe", stall_fe, stall_e);
        checkOutput("bubble", bubble, bub_e);
        if (fw_q.size() < 2) begin
            checkOutput("fw_queue_depth", fw_q.size(), 2);
        end else begin
            prev = fw_q.pop_front();
            checkOutput("fw_a_en", fw_a_en, prev.a_en);
            checkOutput("fw_b_en", fw_b_en, prev.b_en);
            if (prev.a_en) checkOutput("fw_a_sel", fw_a_sel, prev.a_sel);
            if (prev.b_en) checkOutput("fw_b_sel", fw_b_sel, prev.b_sel);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 1'b0; id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rd_we = 1'b0;
        id_no_fw = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_avail = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_stall_fe", stall_fe, 0);
        checkOutput("rst_fw_a_en", fw_a_en, 0);
        checkOutput("rst_fw_b_en", fw_b_en, 0);
        checkOutput("rst_fw_a_sel", fw_a_sel, 0);
        checkOutput("rst_fw_b_sel", fw_b_sel, 0);
        for (int i = 0; i < NSTG; i++) begin
            m_v[i] = 1'b0; m_rd[i] = '0; m_we[i] = 1'b0; m_av[i] = 0;
        end
        m_fw = '{a_en: 1'b0, a_sel: 2'd0, b_en: 1'b0, b_sel: 2'd0};
        fw_q.delete();
        fw_q.push_back(m_fw);
    endtask

    task automatic idle();
        logic iss;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, iss);
    endtask

    task automatic producer(input logic [4:0] rd, input logic [1:0] av, input logic fl);
        logic iss;
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, av, 1'b0, 1'b0, fl, iss);
    endtask

    task automatic consumeUntilIssued(input logic [4:0] rs1, input logic e1, input logic [4:0] rs2,
                                      input logic e2, input logic nofw, output int stalls);
        logic iss;
        stalls = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b1, rs1, e1, rs2, e2, 5'd20, 1'b1, 2'd0, nofw, 1'b0, 1'b0, iss);
            if (iss) return;
            stalls++;
        end
        checkOutput("issue_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   st;
        logic iss;

        doReset();
        idle();

        // ALU x5 -> rs1=x5
        producer(5'd5, 2'd0, 1'b0);
        consumeUntilIssued(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, st);
        checkOutput("alu_stalls", st, FWD ? 0 : 3);
        idle();

        // Load x6 -> rs2=x6
        producer(5'd6, 2'd1, 1'b0);
        consumeUntilIssued(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, st);
        checkOutput("load_stalls", st, FWD ? 1 : 3);
        idle();

        // x0 never creates a dependency
        producer(5'd0, 2'd0, 1'b0);
        consumeUntilIssued(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, st);
        checkOutput("x0_stalls", st, 0);
        idle();

        // Branch consuming x7 in ID cannot forward
        producer(5'd7, 2'd0, 1'b0);
        consumeUntilIssued(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, st);
        checkOutput("nofw_stalls", st, 3);
        idle();

        // Load hazard frozen by stall_ext for 5 cycles mid-stall
        producer(5'd6, 2'd1, 1'b0);
        applyStimulus(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, iss);
        for (int n = 0; n < 5; n++)
            applyStimulus(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, iss);
        consumeUntilIssued(5'd6, 1'b1, 5'd0, 1'b0, 1'b0, st);
        checkOutput("frozen_residual", st, FWD ? 0 : 2);
        idle();

        // Both operands from one producer
        producer(5'd9, 2'd0, 1'b0);
        consumeUntilIssued(5'd9, 1'b1, 5'd9, 1'b1, 1'b0, st);
        checkOutput("shared_stalls", st, FWD ? 0 : 3);
        idle();

        // Youngest match decides over an older one
        producer(5'd10, 2'd0, 1'b0);
        producer(5'd10, 2'd1, 1'b0);
        consumeUntilIssued(5'd10, 1'b1, 5'd0, 1'b0, 1'b0, st);
        checkOutput("youngest_stalls", st, FWD ? 1 : 3);
        idle();

        // Producer in the last stage
        producer(5'd11, 2'd0, 1'b0);
        idle();
        idle();
        consumeUntilIssued(5'd11, 1'b1, 5'd0, 1'b0, 1'b0, st);
        checkOutput("last_stage_stalls", st, FWD ? 0 : 1);
        idle();

        // Flushed producer leaves no dependency
        producer(5'd12, 2'd0, 1'b1);
        consumeUntilIssued(5'd12, 1'b1, 5'd0, 1'b0, 1'b0, st);
        checkOutput("flush_stalls", st, 0);
        idle();

        // Reset with a writer in flight
        producer(5'd13, 2'd1, 1'b0);
        doReset();
        consumeUntilIssued(5'd13, 1'b1, 5'd13, 1'b1, 1'b0, st);
        checkOutput("post_reset_stalls", st, 0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(3) != 0), 5'($urandom_range(7)), 1'($urandom_range(1)),
                          5'($urandom_range(7)), 1'($urandom_range(1)), 5'($urandom_range(7)),
                          1'($urandom_range(1)), 2'($urandom_range(1)), ($urandom_range(7) == 0),
                          ($urandom_range(7) == 0), ($urandom_range(15) == 0), iss);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
